// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: one instruction per handshake, retired 2-5 edges after accept.
// instr_ready is high only while idle; retire_* and branch_* are single-cycle registered pulses.
module multicycle_datapath #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128,
  parameter int MEM_AW    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic              retire_valid,
  output logic              retire_wr_en,
  output logic [4:0]        retire_wr_reg,
  output logic [DATA_W-1:0] retire_wr_data,
  output logic              retire_illegal,
  output logic              retire_fault,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_offset,
  input  logic [4:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, imm, aluout, mdr;
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, dest;
  logic              is_r, is_addi, is_lw, is_sw, is_beq, legal;
  logic [DATA_W-1:0] sext, alu_res, wb_val;
  logic              addr_bad;
  logic [MEM_AW-1:0] mem_idx;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];

  always_comb begin
    is_r    = (opcode == OP_RTYPE);
    is_addi = (opcode == OP_ADDI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    legal   = is_addi | is_lw | is_sw | is_beq;
    if (is_r) begin
      case (funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: legal = 1'b1;
        default:                                       legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    sext       = {DATA_W{ir[15]}};
    sext[15:0] = ir[15:0];
  end

  always_comb begin
    alu_res = '0;
    if (is_r) begin
      case (funct)
        FN_ADD:  alu_res = a + b;
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_NOR:  alu_res = ~(a | b);
        FN_SLT:  alu_res[0] = ($signed(a) < $signed(b));
        default: alu_res = '0;
      endcase
    end else if (is_beq) begin
      alu_res = a - b;
    end else begin
      alu_res = a + imm;
    end
  end

  // Negative addresses are huge when viewed unsigned, so one compare covers both fault cases.
  assign addr_bad = (aluout >= DATA_W'(MEM_DEPTH));
  assign mem_idx  = aluout[MEM_AW-1:0];
  assign dest     = is_r ? rd : rt;
  assign wb_val   = is_lw ? mdr : aluout;

  assign dbg_reg_data = regs[dbg_reg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      instr_ready    <= 1'b1;
      ir             <= '0;
      a              <= '0;
      b              <= '0;
      imm            <= '0;
      aluout         <= '0;
      mdr            <= '0;
      retire_valid   <= 1'b0;
      retire_wr_en   <= 1'b0;
      retire_wr_reg  <= '0;
      retire_wr_data <= '0;
      retire_illegal <= 1'b0;
      retire_fault   <= 1'b0;
      branch_taken   <= 1'b0;
      branch_offset  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      retire_valid   <= 1'b0;
      retire_wr_en   <= 1'b0;
      retire_wr_reg  <= '0;
      retire_wr_data <= '0;
      retire_illegal <= 1'b0;
      retire_fault   <= 1'b0;
      branch_taken   <= 1'b0;
      branch_offset  <= '0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir          <= instruction;
            state       <= DECODE;
            instr_ready <= 1'b0;
          end
        end
        DECODE: begin
          a   <= regs[rs];
          b   <= regs[rt];
          imm <= sext;
          if (!legal) begin
            state          <= IDLE;
            instr_ready    <= 1'b1;
            retire_valid   <= 1'b1;
            retire_illegal <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          aluout <= alu_res;
          if (is_beq) begin
            state         <= IDLE;
            instr_ready   <= 1'b1;
            retire_valid  <= 1'b1;
            branch_taken  <= (alu_res == '0);
            branch_offset <= imm;
          end else if (is_lw || is_sw) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (is_lw) begin
            mdr   <= addr_bad ? '0 : mem[mem_idx];
            state <= WB;
          end else begin
            if (!addr_bad) mem[mem_idx] <= b;
            state        <= IDLE;
            instr_ready  <= 1'b1;
            retire_valid <= 1'b1;
            retire_fault <= addr_bad;
          end
        end
        WB: begin
          // Register 0 is never written, so it reads back as zero without a read-side mux.
          if (dest != 5'd0) regs[dest] <= wb_val;
          state          <= IDLE;
          instr_ready    <= 1'b1;
          retire_valid   <= 1'b1;
          retire_wr_en   <= (dest != 5'd0);
          retire_wr_reg  <= dest;
          retire_wr_data <= wb_val;
          retire_fault   <= is_lw & addr_bad;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Clocked, parametrised multi-cycle MIPS-subset execution core: register file, sign-extend, ALU, data memory and a control FSM.
- Accepts one 32-bit instruction per valid/ready handshake, executes it over 2–5 cycles and reports a one-cycle retire record.
- Sits between the fetch/PC unit, which owns the PC and consumes branch_taken/branch_offset, and the test harness.

Parameters:
- DATA_W, 32, datapath width (registers, ALU, memory words); legal range ≥ 16.
- MEM_DEPTH, 128, data memory depth in words.
- MEM_AW, 7, memory index width; must equal clog2(MEM_DEPTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  instruction offered
- instr_ready  out  1  core idle, can accept
- instruction  in  32  MIPS instruction word
- retire_valid  out  1  one-cycle pulse: instruction completed
- retire_wr_en  out  1  retired instruction wrote a register
- retire_wr_reg  out  5  destination register index
- retire_wr_data  out  DATA_W  value written (or loaded)
- retire_illegal  out  1  unsupported opcode/funct
- retire_fault  out  1  memory address out of range
- branch_taken  out  1  beq condition true (valid with retire_valid)
- branch_offset  out  DATA_W  sign-extended imm16 (word offset)
- dbg_reg_addr  in  5  debug register read index
- dbg_reg_data  out  DATA_W  combinational read of dbg_reg_addr

Behaviour:
- Reset: FSM=IDLE; all 32 registers and all memory words = 0; every retire_* and branch_* output = 0; instr_ready = 1 once reset deasserts.
- Reset mid-instruction: the instruction is abandoned, with no register or memory write and no retire pulse.
- Handshake: instr_ready = (state==IDLE). Transfer on a clk edge with instr_valid & instr_ready; the instruction is latched into IR. instruction is ignored in all other cycles.
- FSM states: IDLE, DECODE, EXEC, MEM, WB.
  - IDLE: go to DECODE on transfer.
  - DECODE: A <= reg[rs], B <= reg[rt], IMM <= sext(imm16). Illegal instruction goes to IDLE; otherwise EXEC.
  - EXEC: ALUOUT <= ALU result. beq goes to IDLE; lw/sw go to MEM; R-type/addi go to WB.
  - MEM: lw captures MDR; sw writes mem[idx] <= B. lw goes to WB; sw goes to IDLE.
  - WB: reg[dest] <= ALUOUT (R/addi) or MDR (lw); go to IDLE.
- Retire: retire_* outputs are registered and pulse high for exactly the first cycle after returning to IDLE. They are 0 in all other cycles.
- Retire latency, counted in edges from the accept edge to retire_valid high:
  - illegal: 2
  - beq: 3
  - R-type, addi, sw: 4
  - lw: 5
- A new instruction may be accepted in the same cycle retire_valid is high.
- Supported operations:
  - R-type (opcode 000000) funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010.
  - I-type: addi 001000, lw 100011, sw 101011, beq 000100.
  - Anything else sets retire_illegal=1 with no side effects.
- Arithmetic:
  - Add/sub wrap modulo 2^DATA_W with no overflow trap.
  - slt is signed two's-complement and yields 1 or 0.
  - beq compares A==B via subtract and sets branch_taken; branch_offset = IMM.
- Destination: rd for R-type, rt for addi/lw. Writes to register 0 are discarded and reg 0 always reads 0. retire_wr_en=0 for a dest-0 write, sw, beq and illegal instructions.
- Memory address: word index = ALUOUT[MEM_AW-1:0].
  - If ALUOUT ≥ MEM_DEPTH or ALUOUT is negative: lw returns 0 and writes it, sw is dropped, and retire_fault=1.
- dbg_reg_data reflects a WB write from the cycle after the WB edge.

Test Plan:
- Assert reset for 2 cycles mid-lw, then deassert → instr_ready=1, dbg reads of all regs = 0, no retire_valid pulse.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 → retire_wr_data 5, 0xFFFFFFFD, 2; add retires 4 edges after accept; dbg reg3 = 2.
- slt $4,$2,$1 with $2=-3 and $1=5 → reg4 = 1 (signed); sub $5,$2,$1 → reg5 = 0xFFFFFFF8; nor $6,$0,$0 → 0xFFFFFFFF.
- sw $1,10($0) then lw $7,10($0) → lw retires at 5 edges with retire_wr_data=5 and reg7=5; lw $8,200($0) → retire_fault=1, reg8=0.
- beq $1,$1,-4 → branch_taken=1 and branch_offset=0xFFFFFFFC at 3 edges; beq $1,$2,+8 → branch_taken=0; addi $0,$0,7 → retire_wr_en=0 and reg0 stays 0.
- Opcode 111111 → retire_illegal=1 at 2 edges with no register change; instr_valid held high continuously → back-to-back accepts occur exactly on the retire cycles.
